eth_header_capture: RTL and testbench

ETH_HEADER_CAPTURE -- requirements
Module: eth_header_capture

---
 rtl/eth_header_capture.sv | 205 ++++++++++++++++++++
 tb/tb_eth_header_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_header_capture.sv
// ============================================================================
// Module   : eth_header_capture
// Purpose  : Captures the leading L2_HEADER_MAX_BYTES bytes of each frame from
//            a byte-wide AXI-Stream-like ingress. It presents the captured
//            bytes and the raw EtherType, reports runt frames, and reports the
//            length of each completed frame.
// Revision : 1.0 - initial release
//
// Parameters
//   L2_HEADER_MAX_BYTES  number of leading frame bytes captured (>= 14 so
//                        that bytes 12/13, the EtherType, are inside the window)
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   s_tvalid       in   ingress byte valid
//   s_tready       out  ingress ready (low in LAST/GAP and while in reset)
//   s_tdata[7:0]   in   ingress byte, wire order
//   s_tlast        in   last byte of frame
//   header_bytes   out  captured bytes, byte i at [8i+7:8i]
//   ethertype_raw  out  {byte12, byte13}
//   fields_valid   out  header_bytes/ethertype_raw complete and stable
//   runt_err       out  1-cycle pulse: frame ended inside the header window
//   frame_len      out  byte count of the last completed frame (saturating)
//   len_valid      out  1-cycle pulse when frame_len updates
//   frame_count    out  (ETH_HEADER_CAPTURE_STATS_EN only) frames completed
//   runt_count     out  (ETH_HEADER_CAPTURE_STATS_EN only) runt frames seen
//
// Build option
//   ETH_HEADER_CAPTURE_STATS_EN  adds the wrapping frame/runt counters above.
// ============================================================================
`default_nettype none

package eth_header_capture_pkg;
  typedef logic [15:0] ethertype_t;
endpackage

module eth_header_capture
  import eth_header_capture_pkg::*;
#(
  parameter int L2_HEADER_MAX_BYTES = 18
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_tvalid,
  output logic                             s_tready,
  input  logic [7:0]                       s_tdata,
  input  logic                             s_tlast,
  output logic [L2_HEADER_MAX_BYTES*8-1:0] header_bytes,
  output ethertype_t                       ethertype_raw,
  output logic                             fields_valid,
  output logic                             runt_err,
  output logic [15:0]                      frame_len,
  output logic                             len_valid
`ifdef ETH_HEADER_CAPTURE_STATS_EN
  ,
  output logic [15:0]                      frame_count,
  output logic [15:0]                      runt_count
`endif
);

  localparam logic [15:0] LAST_IDX = 16'(L2_HEADER_MAX_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    BODY = 3'd2,
    LAST = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;        // accepted bytes so far == index of next byte
  logic [15:0] cnt_nxt;
  logic        accept;
  logic        runt;
  logic        enter_gap;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    s_tready     = 1'b0;
    fields_valid = 1'b0;
    accept       = 1'b0;
    runt         = 1'b0;
    cnt_nxt      = cnt;

    case (state)
      IDLE, HDR: begin
        s_tready = rst_n;
        accept   = s_tvalid && rst_n;
        // cnt is 0 in IDLE, so the same index test serves both states.
        if (accept) begin
          if (cnt < LAST_IDX) begin
            state_nxt = s_tlast ? GAP : HDR;
            runt      = s_tlast;
          end else begin
            state_nxt = s_tlast ? LAST : BODY;
          end
        end
      end
      BODY: begin
        s_tready     = rst_n;
        accept       = s_tvalid && rst_n;
        fields_valid = 1'b1;
        if (accept && s_tlast) begin
          state_nxt = GAP;
        end
      end
      LAST: begin
        fields_valid = 1'b1;
        state_nxt    = GAP;
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (state == GAP) begin
      cnt_nxt = 16'd0;
    end else if (accept && (cnt != 16'hFFFF)) begin
      cnt_nxt = cnt + 16'd1;
    end
  end

  // frame_len/len_valid follow the transition into GAP, whichever state
  // (HDR runt, BODY tlast, LAST) it comes from.
  assign enter_gap = (state_nxt == GAP) && (state != GAP);

  // --------------------------------------------------------------------------
  // Byte counter, frame length, pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 16'd0;
      frame_len <= 16'd0;
      len_valid <= 1'b0;
      runt_err  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      len_valid <= enter_gap;
      runt_err  <= runt;
      if (enter_gap) begin
        frame_len <= cnt_nxt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Header capture: no clearing at frame start, so a runt only overwrites the
  // bytes it actually carried.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      header_bytes <= '0;
    end else begin
      for (int i = 0; i < L2_HEADER_MAX_BYTES; i++) begin
        if (accept && (cnt == 16'(i))) begin
          header_bytes[8*i +: 8] <= s_tdata;
        end
      end
    end
  end

  assign ethertype_raw = {header_bytes[103:96], header_bytes[111:104]};

`ifdef ETH_HEADER_CAPTURE_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics counters (wrapping)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= 16'd0;
      runt_count  <= 16'd0;
    end else begin
      if (enter_gap) begin
        frame_count <= frame_count + 16'd1;
      end
      if (runt) begin
        runt_count <= runt_count + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_eth_header_capture.sv
// ============================================================================
// Module   : tb_eth_header_capture
// Purpose  : Self-checking bench for eth_header_capture. Frames are streamed
//            with random valid gaps; a byte-array model of the header window
//            and frame-level expectations (runt / exact / long frame) provide
//            every expected value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_header_capture;

  localparam int L = 18;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           s_tvalid;
  logic           s_tready;
  logic [7:0]     s_tdata;
  logic           s_tlast;
  logic [L*8-1:0] header_bytes;
  logic [15:0]    ethertype_raw;
  logic           fields_valid;
  logic           runt_err;
  logic [15:0]    frame_len;
  logic           len_valid;
`ifdef ETH_HEADER_CAPTURE_STATS_EN
  logic [15:0]    frame_count;
  logic [15:0]    runt_count;
`endif

  always #5 clk = ~clk;

  eth_header_capture #(
    .L2_HEADER_MAX_BYTES(L)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .s_tlast      (s_tlast),
    .header_bytes (header_bytes),
    .ethertype_raw(ethertype_raw),
    .fields_valid (fields_valid),
    .runt_err     (runt_err),
    .frame_len    (frame_len),
    .len_valid    (len_valid)
`ifdef ETH_HEADER_CAPTURE_STATS_EN
    ,
    .frame_count  (frame_count),
    .runt_count   (runt_count)
`endif
  );

  // Reference state
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] hdr_m [L];
  int         frames_m = 0;
  int         runts_m  = 0;
  logic [7:0] frame_q [$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [L*8-1:0] hdr_vec();
    logic [L*8-1:0] v;
    for (int i = 0; i < L; i++) v[8*i +: 8] = hdr_m[i];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ready",  s_tready,     0);
    check_eq("rst_hdr",    header_bytes, 0);
    check_eq("rst_fv",     fields_valid, 0);
    check_eq("rst_runt",   runt_err,     0);
    check_eq("rst_flen",   frame_len,    0);
    check_eq("rst_lvalid", len_valid,    0);
`ifdef ETH_HEADER_CAPTURE_STATS_EN
    check_eq("rst_fcnt",   frame_count,  0);
    check_eq("rst_rcnt",   runt_count,   0);
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < L; i++) hdr_m[i] = 8'h00;
    frames_m = 0;
    runts_m  = 0;
  endtask

  task automatic fill_random(input int len);
    frame_q.delete();
    for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
  endtask

  // Streams frame_q (called with the DUT idle) and checks the frame outcome.
  task automatic send_frame(input int gap_pct);
    int len;
    len = frame_q.size();
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        s_tvalid = 1'b0;
        s_tdata  = 8'($urandom);
        s_tlast  = 1'($urandom);
        @(negedge clk);
        check_eq("stall_fv",    fields_valid, (i >= L));
        check_eq("stall_ready", s_tready,     1);
        step();
      end
      s_tvalid = 1'b1;
      s_tdata  = frame_q[i];
      s_tlast  = (i == len - 1);
      @(negedge clk);
      check_eq("byte_ready", s_tready,     1);
      check_eq("byte_fv",    fields_valid, (i >= L));
      step();
      if (i < L) hdr_m[i] = frame_q[i];
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 8'($urandom);
    frames_m++;
    if (len < L) runts_m++;

    @(negedge clk);
    check_eq("hdr",       header_bytes,  hdr_vec());
    check_eq("ethertype", ethertype_raw, {hdr_m[12], hdr_m[13]});
    if (len == L) begin
      check_eq("last_fv",     fields_valid, 1);
      check_eq("last_ready",  s_tready,     0);
      check_eq("last_lvalid", len_valid,    0);
      check_eq("last_runt",   runt_err,     0);
      step();
      @(negedge clk);
    end
    check_eq("gap_fv",     fields_valid, 0);
    check_eq("gap_ready",  s_tready,     0);
    check_eq("gap_lvalid", len_valid,    1);
    check_eq("gap_flen",   frame_len,    len);
    check_eq("gap_runt",   runt_err,     (len < L));
    step();
    @(negedge clk);
    check_eq("idle_ready",  s_tready,     1);
    check_eq("idle_lvalid", len_valid,    0);
    check_eq("idle_runt",   runt_err,     0);
    check_eq("idle_fv",     fields_valid, 0);
    check_eq("idle_flen",   frame_len,    len);
`ifdef ETH_HEADER_CAPTURE_STATS_EN
    check_eq("frame_count", frame_count, 16'(frames_m));
    check_eq("runt_count",  runt_count,  16'(runts_m));
`endif
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tlast  = 1'b0;
    model_reset();
    #3;
    check_reset_outputs();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 60-byte frame, EtherType 0x0800, continuous valid
    fill_random(60);
    frame_q[12] = 8'h08;
    frame_q[13] = 8'h00;
    send_frame(0);
    check_eq("et_0800", ethertype_raw, 16'h0800);

    // 22-byte VLAN-tagged frame
    fill_random(22);
    frame_q[12] = 8'h81;
    frame_q[13] = 8'h00;
    frame_q[16] = 8'h86;
    frame_q[17] = 8'hDD;
    send_frame(0);
    check_eq("et_8100",   ethertype_raw,         16'h8100);
    check_eq("inner_et",  header_bytes[143:128], 16'hDD86);

    // 10-byte runt: bytes 10..17 must keep the previous frame's contents
    fill_random(10);
    send_frame(0);

    // Exactly header-sized frame
    fill_random(L);
    send_frame(0);

    // Reset in the middle of a frame, right after byte 7 is accepted
    fill_random(8);
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = frame_q[i];
      s_tlast  = 1'b0;
      step();
    end
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_outputs();
    @(negedge clk);
    check_eq("rst_hold_ready", s_tready, 0);
    step();
    s_tvalid = 1'b0;
    rst_n    = 1'b1;
    step();
    fill_random(64);
    send_frame(0);

    // 64-byte frame, EtherType 0x0800, random valid gaps
    fill_random(64);
    frame_q[12] = 8'h08;
    frame_q[13] = 8'h00;
    send_frame(40);
    check_eq("et_0800_gaps", ethertype_raw, 16'h0800);

    // Random frames and random gap density
    for (int f = 0; f < 30; f++) begin
      fill_random(int'($urandom_range(1, 70)));
      send_frame(int'($urandom_range(0, 50)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
